// File: rtl/ldl_rr_arbiter.sv
// ldl_rr_arbiter: registered round-robin arbiter with grant lock.
// One requester is granted at a time and holds the grant until released.
// On release the priority origin (ptr) moves to the slot just past the winner.
// ptr feeds the downstream ring left shifter as its rotation amount.
// Optional feature macro: LDL_RR_ARB_DROP_RELEASE_EN. When it is defined, a
// withdrawn request from the current owner also releases the grant.
module ldl_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int PW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req,
  input  logic             done,
  output logic [WIDTH-1:0] gnt,
  output logic             gnt_vld,
  output logic [PW-1:0]    gnt_idx,
  output logic [PW-1:0]    ptr
);

  typedef enum logic {IDLE, BUSY} state_e;

  // One extra bit so ptr+k cannot overflow before the explicit wrap.
  localparam logic [PW:0]   WIDTH_P = (PW+1)'(WIDTH);
  localparam logic [PW-1:0] LAST    = PW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] gnt_q, gnt_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic [PW-1:0]    gnt_idx_q, gnt_idx_d;
  logic [PW-1:0]    ptr_q, ptr_d;

  logic [PW-1:0]    win;
  logic             found;
  logic [PW:0]      cand;
  logic             release_evt;

`ifdef LDL_RR_ARB_DROP_RELEASE_EN
  // The owner dropping its request counts as a release; OR-ing keeps a
  // simultaneous done and drop down to a single release.
  assign release_evt = done | ~req[gnt_idx_q];
`else
  // Only done releases; a withdrawn request keeps the grant locked.
  assign release_evt = done;
`endif

  // Search requesters starting at ptr, wrapping by compare/subtract so that
  // non-power-of-two widths wrap at WIDTH rather than at 2**PW.
  always_comb begin
    // NOTE: blocking assignments here are intentional; cand and found are
    // scratch values that each iteration must see updated immediately.
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < WIDTH; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= WIDTH_P) cand = cand - WIDTH_P;
      if (!found && req[cand[PW-1:0]]) begin
        found = 1'b1;
        win   = cand[PW-1:0];
      end
    end
  end

  // Next-state and next-output logic for the IDLE/BUSY grant FSM.
  always_comb begin
    // NOTE: every target gets a hold-value default first so no path through
    // the case can leave a signal unassigned and infer a latch.
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_vld_d = gnt_vld_q;
    gnt_idx_d = gnt_idx_q;
    ptr_d     = ptr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          gnt_idx_d  = win;
          gnt_vld_d  = 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (release_evt) begin
          gnt_d     = '0;
          gnt_vld_d = 1'b0;
          ptr_d     = (gnt_idx_q == LAST) ? '0 : gnt_idx_q + 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; async reset clears everything mid-grant.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so all registers update together on the
    // edge regardless of statement order.
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      gnt_idx_q <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_idx_q <= gnt_idx_d;
      ptr_q     <= ptr_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = gnt_vld_q;
  assign gnt_idx = gnt_idx_q;
  assign ptr     = ptr_q;

endmodule

// File: tb/tb_ldl_rr_arbiter.sv
// Testbench for ldl_rr_arbiter: an 8-wide and a 5-wide instance.
// Table-driven vectors go through a scoreboard queue; reset and lock cases
// are hand-written sequences.
module tb_ldl_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req8 = '0;
  logic       done8 = 1'b0;
  logic [7:0] gnt8;
  logic       vld8;
  logic [2:0] idx8, ptr8;
  logic [4:0] req5 = '0;
  logic       done5 = 1'b0;
  logic [4:0] gnt5;
  logic       vld5;
  logic [2:0] idx5, ptr5;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ldl_rr_arbiter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .done(done8),
    .gnt(gnt8), .gnt_vld(vld8), .gnt_idx(idx8), .ptr(ptr8));

  ldl_rr_arbiter #(.WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .done(done5),
    .gnt(gnt5), .gnt_vld(vld5), .gnt_idx(idx5), .ptr(ptr5));

  typedef struct {
    logic       w5;    // 1: apply to the 5-wide instance
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic       vld;
    logic [2:0] idx;
    logic [2:0] ptr;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector, push its expectation, clock, then pop and compare.
  task automatic step(input vec_t v);
    vec_t e;
    if (v.w5) begin
      req5 = v.req[4:0]; done5 = v.done;
    end else begin
      req8 = v.req; done8 = v.done;
    end
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.w5) begin
      check("gnt5", {3'b0, gnt5}, e.gnt);
      check("vld5", vld5, e.vld);
      check("idx5", idx5, e.idx);
      check("ptr5", ptr5, e.ptr);
    end else begin
      check("gnt8", gnt8, e.gnt);
      check("vld8", vld8, e.vld);
      check("idx8", idx8, e.idx);
      check("ptr8", ptr8, e.ptr);
    end
    done5 = 1'b0;
    done8 = 1'b0;
  endtask

  function automatic vec_t mk(input logic w5, input logic [7:0] r, input logic d,
                              input logic [7:0] g, input logic vl,
                              input logic [2:0] ix, input logic [2:0] p);
    vec_t v;
    v.w5 = w5; v.req = r; v.done = d; v.gnt = g; v.vld = vl; v.idx = ix; v.ptr = p;
    return v;
  endfunction

  initial begin
    // Fair rotation: grants 01..80 then 01 again; ptr tracks winner+1.
    for (int i = 0; i < 9; i++) begin
      tbl.push_back(mk(0, 8'hFF, 0, 8'h01 << (i % 8), 1, 3'(i % 8), 3'(i % 8)));
      tbl.push_back(mk(0, 8'hFF, 1, 8'h00, 0, 3'(i % 8), 3'((i + 1) % 8)));
    end
    // Move ptr to 6 by granting requester 5, then the priority-skip case.
    tbl.push_back(mk(0, 8'h20, 0, 8'h20, 1, 3'd5, 3'd1));
    tbl.push_back(mk(0, 8'h20, 1, 8'h00, 0, 3'd5, 3'd6));
    tbl.push_back(mk(0, 8'h05, 0, 8'h01, 1, 3'd0, 3'd6));
    tbl.push_back(mk(0, 8'h05, 0, 8'h01, 1, 3'd0, 3'd6));
    tbl.push_back(mk(0, 8'h05, 1, 8'h00, 0, 3'd0, 3'd1));
    // done in IDLE with no request: nothing moves.
    tbl.push_back(mk(0, 8'h00, 1, 8'h00, 0, 3'd0, 3'd1));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 3'd0, 3'd1));
    tbl.push_back(mk(0, 8'h00, 1, 8'h00, 0, 3'd0, 3'd1));

    // Reset state.
    #2;
    check("rst_gnt", gnt8, 8'h00);
    check("rst_vld", vld8, 1'b0);
    check("rst_idx", idx8, 3'd0);
    check("rst_ptr", ptr8, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) step(tbl[i]);

    // Lock: grant requester 3, withdraw it, hold done low for 10 cycles.
    step(mk(0, 8'h08, 0, 8'h08, 1, 3'd3, 3'd1));
    for (int j = 0; j < 10; j++) begin
`ifdef LDL_RR_ARB_DROP_RELEASE_EN
      step(mk(0, 8'h00, 0, 8'h00, 0, 3'd3, 3'd4));
`else
      step(mk(0, 8'h00, 0, 8'h08, 1, 3'd3, 3'd1));
`endif
    end
    step(mk(0, 8'h00, 1, 8'h00, 0, 3'd3, 3'd4));

    // Reset mid-grant with gnt=10: outputs clear without a clock edge.
    step(mk(0, 8'h10, 0, 8'h10, 1, 3'd4, 3'd4));
    #2;
    rst_n = 1'b0;
    #1;
    check("amid_gnt", gnt8, 8'h00);
    check("amid_vld", vld8, 1'b0);
    check("amid_idx", idx8, 3'd0);
    check("amid_ptr", ptr8, 3'd0);
    req8 = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(mk(0, 8'hFF, 0, 8'h01, 1, 3'd0, 3'd0));
    step(mk(0, 8'hFF, 1, 8'h00, 0, 3'd0, 3'd1));

    // Non-power-of-two width: reach ptr=4, winner 4 wraps ptr to 0.
    step(mk(1, 8'h08, 0, 8'h08, 1, 3'd3, 3'd0));
    step(mk(1, 8'h08, 1, 8'h00, 0, 3'd3, 3'd4));
    step(mk(1, 8'h10, 0, 8'h10, 1, 3'd4, 3'd4));
    step(mk(1, 8'h10, 1, 8'h00, 0, 3'd4, 3'd0));
    step(mk(1, 8'h02, 0, 8'h02, 1, 3'd1, 3'd0));
    step(mk(1, 8'h02, 1, 8'h00, 0, 3'd1, 3'd2));

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ldl_rr_arbiter.md
# ldl_rr_arbiter

Registered round-robin arbiter with grant lock and a rotating priority pointer. It sits directly upstream of the library's ring left shifter: `ptr` is the rotation amount that stage consumes, so downstream data and request vectors can be re-aligned to the current priority origin. It grants one requester at a time and holds the grant until it is released. The pointer then advances past the winner.

## Interface
Parameters:
- `WIDTH`, default 8: number of requesters; legal range is 2 or more; need not be a power of two.
- `PW`, default `$clog2(WIDTH)`: derived index width; never overridden.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `req`, input, `WIDTH`: request vector, bit i = requester i.
- `done`, input, 1: release strobe for the current grant; ignored when no grant is held.
- `gnt`, output, `WIDTH`: registered one-hot grant, or all zero.
- `gnt_vld`, output, 1: registered; high while a grant is held; equals `|gnt`.
- `gnt_idx`, output, `PW`: registered binary index of the granted requester; holds its last value when `gnt_vld`=0.
- `ptr`, output, `PW`: registered priority origin, range 0..`WIDTH`-1; drives the downstream rotator `sel`.

## Operation
- The FSM has two states, IDLE and BUSY.
- **Reset:** state=IDLE, `gnt`=0, `gnt_vld`=0, `gnt_idx`=0, `ptr`=0.
- **IDLE with `req`=0:** no change.
- **IDLE with `req`≠0:**
  - Form r = `req` rotated right by `ptr`, modulo `WIDTH`, so bit `ptr` lands at r[0].
  - k = index of the lowest set bit of r.
  - winner = (`ptr`+k) mod `WIDTH`.
  - Register `gnt`=onehot(winner), `gnt_idx`=winner, `gnt_vld`=1, then go to BUSY.
- **BUSY:**
  - `gnt` and `gnt_idx` are frozen.
  - `req` changes, including on the granted bit, have no effect unless the configuration macro is defined.
- **BUSY with `done`=1:**
  - `gnt`=0 and `gnt_vld`=0.
  - `ptr`=winner+1, or 0 if winner+1=`WIDTH`.
  - Go to IDLE.
- `done` in IDLE is ignored; it is not stored.
- `ptr` changes only on release. It never changes while IDLE or while a grant is held.
- Modulo arithmetic must use explicit compare/subtract, not bit truncation, so non-power-of-two `WIDTH` wraps correctly (e.g. `WIDTH`=5, winner 4 gives `ptr`=0).
- **Simultaneous events:** on the release cycle, any new `req` is not evaluated. Arbitration happens in the next IDLE cycle using the updated `ptr`.

## Timing
- **Grant latency:** `req` sampled in IDLE at edge n drives `gnt`/`gnt_vld` high after edge n; they are visible in cycle n+1.
- **Release latency:** `done` sampled at edge m drops `gnt_vld` and updates `ptr` after edge m.
- **Minimum turnaround:** one IDLE cycle between grants. With a continuous request and `done` pulsed every BUSY cycle, `gnt_vld` toggles 1,0,1,0…
- Outputs are glitch-free registers with no combinational path from `req` or `done` to any output.
- **Reset mid-grant:** asserting `rst_n`=0 clears all outputs asynchronously, with no waiting for `done`. After reset release, arbitration restarts at `ptr`=0.

## Configuration
- `LDL_RR_ARB_DROP_RELEASE_EN`
- **Defined:** in BUSY, `req[gnt_idx]`=0 is treated exactly as `done`=1, with the same release, pointer update and latency. If both occur in the same cycle, a single release results.
- **Undefined:** only `done` releases a grant. A withdrawn request keeps the grant locked.

## Test plan
- **Reset state:** Assert `rst_n`=0 mid-BUSY, with `WIDTH`=8 and `gnt`=8'h10. Required: `gnt`=0, `gnt_vld`=0, `gnt_idx`=0 and `ptr`=0 immediately, without waiting for a clock edge. The first grant after reset with `req`=8'hFF is 8'h01.
- **Fair rotation:** Hold `req`=8'hFF and pulse `done` on every BUSY cycle. Required: grants are 01,02,04,…,80,01 and `ptr` runs 1..7 then wraps to 0.
- **Priority skip:** Start from `ptr`=6 with `req`=8'h05. Required: `gnt`=8'h01, `gnt_idx`=0, and `ptr` after release is 1.
- **Non-power-of-two width:** With `WIDTH`=5, `ptr`=4 and `req`=5'b10000, grant then release. Required: `gnt_idx`=4 and `ptr`=0. Next, `req`=5'b00010 is granted with `gnt_idx`=1.
- **Lock and ignore:**
  - Grant requester 3, deassert `req[3]` and hold `done`=0 for 10 cycles. Required with the macro undefined: `gnt` stays 8'h08. Required with the macro defined: release occurs 1 cycle after the drop and `ptr`=4.
  - Pulse `done` while IDLE with `req`=0. Required: no state or `ptr` change.
